// File: rtl/rfphoenix_vrf_wb_arbiter_if.sv
// Writeback bus between the vector-regfile writeback sources and the arbiter.
// It carries the request side and the registered regfile write port.
interface rfphoenix_vrf_wb_arbiter_if #(
   parameter int NREQ   = 3,
   parameter int NLANES = 16,
   parameter int TIDW   = 4,
   parameter int REGW   = 6
);
   localparam int GIDW = $clog2(NREQ);

   logic [NREQ-1:0]           req_valid;
   logic [NREQ-1:0]           req_ready;
   logic [NREQ*TIDW-1:0]      req_thread;
   logic [NREQ*REGW-1:0]      req_reg;
   logic [NREQ*NLANES*4-1:0]  req_mask;
   logic [NREQ*NLANES*32-1:0] req_data;

   logic                      wr;
   logic [TIDW-1:0]           wthread;
   logic [REGW-1:0]           wa;
   logic [NLANES*4-1:0]       wmask;
   logic [NLANES*32-1:0]      wdata;
   logic [GIDW-1:0]           grant_id;
   logic                      starve;

   modport slave (
      input  req_valid, req_thread, req_reg, req_mask, req_data,
      output req_ready, wr, wthread, wa, wmask, wdata, grant_id, starve
   );

   modport master (
      output req_valid, req_thread, req_reg, req_mask, req_data,
      input  req_ready, wr, wthread, wa, wmask, wdata, grant_id, starve
   );
endinterface

// File: rtl/rfphoenix_vrf_wb_arbiter.sv
// Round-robin writeback arbiter for the vector regfile write port, with an
// age-based starvation override and a one-stage registered write output.
module rfphoenix_vrf_wb_arbiter #(
   parameter int NREQ    = 3,
   parameter int NLANES  = 16,
   parameter int TIDW    = 4,
   parameter int REGW    = 6,
   parameter int AGE_MAX = 7
) (
   input  logic clk,
   input  logic rst,
   input  logic ce,
   rfphoenix_vrf_wb_arbiter_if.slave bus
);
   localparam int GIDW = $clog2(NREQ);
   localparam int AGEW = $clog2(AGE_MAX + 1);
   localparam int MW   = NLANES * 4;
   localparam int DW   = NLANES * 32;
   localparam logic [AGEW-1:0] AGE_SAT = AGEW'(AGE_MAX);
   localparam logic [GIDW-1:0] LAST_ID = GIDW'(NREQ - 1);

   logic [GIDW-1:0] rr_q;
   logic [AGEW-1:0] age_q [NREQ];
   logic [AGEW-1:0] age_d [NREQ];

   logic            wr_q;
   logic [TIDW-1:0] wthread_q;
   logic [REGW-1:0] wa_q;
   logic [MW-1:0]   wmask_q;
   logic [DW-1:0]   wdata_q;
   logic [GIDW-1:0] grant_id_q;
   logic            starve_q;

   logic            win_found;
   logic            win_ovr;
   logic [GIDW-1:0] win_idx;
   logic [GIDW-1:0] cand;
   logic [NREQ-1:0] grant;
   logic            xfer;
   logic [TIDW-1:0] sel_thread;
   logic [REGW-1:0] sel_reg;
   logic [MW-1:0]   sel_mask;
   logic [DW-1:0]   sel_data;

   // Descending scans so the lowest aged index / nearest rr candidate is the last writer.
   always_comb begin
      win_found = 1'b0;
      win_ovr   = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (bus.req_valid[i] && (age_q[i] == AGE_SAT)) begin
            win_found = 1'b1;
            win_ovr   = 1'b1;
            win_idx   = GIDW'(i);
         end
      end
      if (!win_ovr) begin
         for (int off = NREQ - 1; off >= 0; off--) begin
            cand = GIDW'((int'(rr_q) + off) % NREQ);
            if (bus.req_valid[cand]) begin
               win_found = 1'b1;
               win_idx   = cand;
            end
         end
      end
   end

   // Nothing is accepted while held in reset or stalled.
   always_comb begin
      grant = '0;
      if (ce && rst && win_found) grant[win_idx] = 1'b1;
   end

   assign xfer       = |grant;
   assign sel_thread = bus.req_thread[win_idx*TIDW +: TIDW];
   assign sel_reg    = bus.req_reg[win_idx*REGW +: REGW];
   assign sel_mask   = bus.req_mask[win_idx*MW +: MW];
   assign sel_data   = bus.req_data[win_idx*DW +: DW];

   always_comb begin
      for (int k = 0; k < NREQ; k++) begin
         age_d[k] = age_q[k];
         if (!bus.req_valid[k] || grant[k]) age_d[k] = '0;
         else if (age_q[k] != AGE_SAT)      age_d[k] = age_q[k] + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_q       <= '0;
         wr_q       <= 1'b0;
         wthread_q  <= '0;
         wa_q       <= '0;
         wmask_q    <= '0;
         wdata_q    <= '0;
         grant_id_q <= '0;
         starve_q   <= 1'b0;
         for (int k = 0; k < NREQ; k++) age_q[k] <= '0;
      end else if (ce) begin
         wr_q     <= xfer & (|sel_mask);
         starve_q <= xfer & win_ovr;
         if (xfer) begin
            wthread_q  <= sel_thread;
            wa_q       <= sel_reg;
            wmask_q    <= sel_mask;
            wdata_q    <= sel_data;
            grant_id_q <= win_idx;
            rr_q       <= (win_idx == LAST_ID) ? '0 : win_idx + 1'b1;
         end
         for (int k = 0; k < NREQ; k++) age_q[k] <= age_d[k];
      end
   end

   assign bus.req_ready = grant;
   assign bus.wr        = wr_q;
   assign bus.wthread   = wthread_q;
   assign bus.wa        = wa_q;
   assign bus.wmask     = wmask_q;
   assign bus.wdata     = wdata_q;
   assign bus.grant_id  = grant_id_q;
   assign bus.starve    = starve_q;
endmodule

// File: tb/tb_rfphoenix_vrf_wb_arbiter.sv
// Bench for the writeback arbiter: a default instance and a short-age instance
// share stimulus; a table, hand sequences and random traffic check both.
module tb_rfphoenix_vrf_wb_arbiter;
   localparam int N  = 3;
   localparam int NL = 16;
   localparam int TW = 4;
   localparam int RW = 6;
   localparam int MW = NL * 4;
   localparam int DW = NL * 32;

   typedef struct {
      logic [2:0] rdy;
      logic       wr;
      logic [1:0] gid;
      logic       st;
   } exp_t;

   typedef struct {
      logic [2:0] v;
      logic       c;
      logic [2:0] zm;
      exp_t       e;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic ce  = 1'b0;
   always #5 clk = ~clk;

   rfphoenix_vrf_wb_arbiter_if #(.NREQ(N), .NLANES(NL), .TIDW(TW), .REGW(RW)) bus_a ();
   rfphoenix_vrf_wb_arbiter_if #(.NREQ(N), .NLANES(NL), .TIDW(TW), .REGW(RW)) bus_b ();

   rfphoenix_vrf_wb_arbiter #(.NREQ(N), .NLANES(NL), .TIDW(TW), .REGW(RW), .AGE_MAX(7)) u_dut (
      .clk(clk), .rst(rst), .ce(ce), .bus(bus_a));
   rfphoenix_vrf_wb_arbiter #(.NREQ(N), .NLANES(NL), .TIDW(TW), .REGW(RW), .AGE_MAX(1)) u_age (
      .clk(clk), .rst(rst), .ce(ce), .bus(bus_b));

   int tests = 0;
   int fails = 0;

   logic [TW-1:0] th [N];
   logic [RW-1:0] rg [N];
   logic [MW-1:0] mk [N];
   logic [DW-1:0] dt [N];
   logic [2:0]    prev_v;
   int            prev_g;

   // Reference model: index 0 mirrors u_dut, index 1 mirrors u_age.
   int            amax  [2] = '{7, 1};
   int            m_rr  [2];
   int            m_age [2][N];
   int            m_win [2];
   bit            m_ovr [2];
   logic          e_wr  [2];
   logic [TW-1:0] e_th  [2];
   logic [RW-1:0] e_wa  [2];
   logic [MW-1:0] e_mk  [2];
   logic [DW-1:0] e_dt  [2];
   logic [1:0]    e_gid [2];
   logic          e_st  [2];

   exp_t EX0 = '{3'b000, 1'b0, 2'd0, 1'b0};
   vec_t tbl [16];

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int n = 0; n < 2; n++) begin
         m_rr[n] = 0;
         for (int k = 0; k < N; k++) m_age[n][k] = 0;
         m_win[n] = -1; m_ovr[n] = 0;
         e_wr[n] = 0; e_th[n] = '0; e_wa[n] = '0; e_mk[n] = '0;
         e_dt[n] = '0; e_gid[n] = '0; e_st[n] = 0;
      end
   endtask

   task automatic pick(input int n, input logic [2:0] v, input logic c);
      m_win[n] = -1;
      m_ovr[n] = 0;
      if (c && rst) begin
         for (int i = 0; i < N; i++)
            if (v[i] && m_age[n][i] == amax[n]) begin m_win[n] = i; m_ovr[n] = 1; break; end
         if (m_win[n] < 0)
            for (int off = 0; off < N; off++) begin
               int i;
               i = (m_rr[n] + off) % N;
               if (v[i]) begin m_win[n] = i; break; end
            end
      end
   endtask

   task automatic model_edge(input logic [2:0] v, input logic c);
      for (int n = 0; n < 2; n++) begin
         if (c) begin
            if (m_win[n] >= 0) begin
               int w;
               w = m_win[n];
               e_wr[n] = |mk[w]; e_th[n] = th[w]; e_wa[n] = rg[w];
               e_mk[n] = mk[w];  e_dt[n] = dt[w]; e_gid[n] = 2'(w);
               e_st[n] = m_ovr[n];
               m_rr[n] = (w + 1) % N;
            end else begin
               e_wr[n] = 0; e_st[n] = 0;
            end
            for (int k = 0; k < N; k++) begin
               if (!v[k] || k == m_win[n])     m_age[n][k] = 0;
               else if (m_age[n][k] < amax[n]) m_age[n][k]++;
            end
         end
      end
      prev_v = v;
      prev_g = c ? m_win[0] : -1;
   endtask

   // A requester only presents new fields when it was idle or just accepted.
   task automatic drive(input logic [2:0] v, input logic c, input logic [2:0] zm);
      for (int k = 0; k < N; k++) begin
         if (!prev_v[k] || prev_g == k) begin
            th[k] = TW'($urandom());
            rg[k] = RW'($urandom());
            mk[k] = {$urandom(), $urandom()};
            if (mk[k] == '0) mk[k] = 1;
            if (zm[k]) mk[k] = '0;
            for (int j = 0; j < NL; j++) dt[k][j*32 +: 32] = $urandom();
         end
         bus_a.req_thread[k*TW +: TW] = th[k]; bus_b.req_thread[k*TW +: TW] = th[k];
         bus_a.req_reg[k*RW +: RW]    = rg[k]; bus_b.req_reg[k*RW +: RW]    = rg[k];
         bus_a.req_mask[k*MW +: MW]   = mk[k]; bus_b.req_mask[k*MW +: MW]   = mk[k];
         bus_a.req_data[k*DW +: DW]   = dt[k]; bus_b.req_data[k*DW +: DW]   = dt[k];
      end
      bus_a.req_valid = v;
      bus_b.req_valid = v;
      ce = c;
   endtask

   task automatic out_chk(input string p, input int n, input logic wr, input logic [TW-1:0] wt,
                          input logic [RW-1:0] wa, input logic [MW-1:0] wm, input logic [DW-1:0] wd,
                          input logic [1:0] gid, input logic st);
      chk({p, "_wr"}, wr, e_wr[n]);
      chk({p, "_wthread"}, wt, e_th[n]);
      chk({p, "_wa"}, wa, e_wa[n]);
      chk({p, "_wmask"}, wm, e_mk[n]);
      chk({p, "_wdata"}, wd, e_dt[n]);
      chk({p, "_grant_id"}, gid, e_gid[n]);
      chk({p, "_starve"}, st, e_st[n]);
   endtask

   // Entered at posedge+1; returns at the following posedge+1.
   task automatic step(input logic [2:0] v, input logic c, input logic [2:0] zm,
                       input bit ca, input exp_t ea, input bit cb, input exp_t eb);
      logic [2:0] er [2];
      drive(v, c, zm);
      #3;
      for (int n = 0; n < 2; n++) begin
         pick(n, v, c);
         er[n] = '0;
         if (m_win[n] >= 0) er[n][m_win[n]] = 1'b1;
      end
      chk("ready_a", bus_a.req_ready, er[0]);
      chk("ready_b", bus_b.req_ready, er[1]);
      if (ca) chk("tbl_ready_a", bus_a.req_ready, ea.rdy);
      if (cb) chk("tbl_ready_b", bus_b.req_ready, eb.rdy);
      @(posedge clk);
      model_edge(v, c);
      #1;
      out_chk("a", 0, bus_a.wr, bus_a.wthread, bus_a.wa, bus_a.wmask, bus_a.wdata, bus_a.grant_id, bus_a.starve);
      out_chk("b", 1, bus_b.wr, bus_b.wthread, bus_b.wa, bus_b.wmask, bus_b.wdata, bus_b.grant_id, bus_b.starve);
      if (ca) begin
         chk("tbl_wr_a", bus_a.wr, ea.wr);
         chk("tbl_gid_a", bus_a.grant_id, ea.gid);
         chk("tbl_starve_a", bus_a.starve, ea.st);
      end
      if (cb) begin
         chk("tbl_wr_b", bus_b.wr, eb.wr);
         chk("tbl_gid_b", bus_b.grant_id, eb.gid);
         chk("tbl_starve_b", bus_b.starve, eb.st);
      end
   endtask

   // Releases reset mid-cycle with ce low so the first real cycle is the caller's.
   task automatic release_reset();
      ce = 1'b0;
      #3 rst = 1'b1;
      @(posedge clk);
      #1;
      prev_v = 3'b000;
      prev_g = -1;
   endtask

   initial begin
      tbl[0]  = '{3'b111, 1'b1, 3'b000, '{3'b001, 1'b1, 2'd0, 1'b0}};
      tbl[1]  = '{3'b111, 1'b1, 3'b000, '{3'b010, 1'b1, 2'd1, 1'b0}};
      tbl[2]  = '{3'b111, 1'b1, 3'b000, '{3'b100, 1'b1, 2'd2, 1'b0}};
      tbl[3]  = '{3'b111, 1'b1, 3'b000, '{3'b001, 1'b1, 2'd0, 1'b0}};
      tbl[4]  = '{3'b111, 1'b1, 3'b000, '{3'b010, 1'b1, 2'd1, 1'b0}};
      tbl[5]  = '{3'b111, 1'b1, 3'b000, '{3'b100, 1'b1, 2'd2, 1'b0}};
      tbl[6]  = '{3'b111, 1'b0, 3'b000, '{3'b000, 1'b1, 2'd2, 1'b0}};
      tbl[7]  = '{3'b111, 1'b0, 3'b000, '{3'b000, 1'b1, 2'd2, 1'b0}};
      tbl[8]  = '{3'b111, 1'b0, 3'b000, '{3'b000, 1'b1, 2'd2, 1'b0}};
      tbl[9]  = '{3'b111, 1'b1, 3'b000, '{3'b001, 1'b1, 2'd0, 1'b0}};
      tbl[10] = '{3'b000, 1'b1, 3'b000, '{3'b000, 1'b0, 2'd0, 1'b0}};
      tbl[11] = '{3'b010, 1'b1, 3'b010, '{3'b010, 1'b0, 2'd1, 1'b0}};
      tbl[12] = '{3'b001, 1'b1, 3'b000, '{3'b001, 1'b1, 2'd0, 1'b0}};
      tbl[13] = '{3'b100, 1'b1, 3'b000, '{3'b100, 1'b1, 2'd2, 1'b0}};
      tbl[14] = '{3'b110, 1'b1, 3'b000, '{3'b010, 1'b1, 2'd1, 1'b0}};
      tbl[15] = '{3'b011, 1'b1, 3'b000, '{3'b001, 1'b1, 2'd0, 1'b0}};

      // Held in reset with every requester valid.
      model_reset();
      prev_v = 3'b000;
      prev_g = -1;
      drive(3'b111, 1'b1, 3'b000);
      #12;
      chk("rst_ready_a", bus_a.req_ready, 3'b000);
      chk("rst_ready_b", bus_b.req_ready, 3'b000);
      out_chk("rst_a", 0, bus_a.wr, bus_a.wthread, bus_a.wa, bus_a.wmask, bus_a.wdata, bus_a.grant_id, bus_a.starve);
      chk("rst_wr_b", bus_b.wr, 1'b0);
      release_reset();
      prev_v = 3'b111;

      for (int i = 0; i < 16; i++)
         step(tbl[i].v, tbl[i].c, tbl[i].zm, 1'b1, tbl[i].e, 1'b0, EX0);

      // Asynchronous reset between edges while a write is on the port.
      chk("pre_arst_wr_a", bus_a.wr, 1'b1);
      #2 rst = 1'b0;
      #1;
      chk("arst_wr_a", bus_a.wr, 1'b0);
      chk("arst_wmask_a", bus_a.wmask, '0);
      chk("arst_gid_a", bus_a.grant_id, 2'd0);
      chk("arst_ready_a", bus_a.req_ready, 3'b000);
      chk("arst_wr_b", bus_b.wr, 1'b0);
      model_reset();
      @(posedge clk);
      #1;
      chk("arst_hold_ready_a", bus_a.req_ready, 3'b000);
      release_reset();

      // Aged requester 2 overrides the rr pointer in the short-age instance only.
      step(3'b101, 1'b1, 3'b000, 1'b1, '{3'b001, 1'b1, 2'd0, 1'b0}, 1'b1, '{3'b001, 1'b1, 2'd0, 1'b0});
      step(3'b110, 1'b1, 3'b000, 1'b1, '{3'b010, 1'b1, 2'd1, 1'b0}, 1'b1, '{3'b100, 1'b1, 2'd2, 1'b1});
      step(3'b000, 1'b1, 3'b000, 1'b1, '{3'b000, 1'b0, 2'd1, 1'b0}, 1'b1, '{3'b000, 1'b0, 2'd2, 1'b0});

      for (int i = 0; i < 400; i++) begin
         logic [2:0] v, zm;
         logic       c;
         v  = 3'($urandom_range(0, 7));
         c  = ($urandom_range(0, 9) != 0);
         zm = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
         step(v, c, zm, 1'b0, EX0, 1'b0, EX0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
